// File: rtl/wb_regfile_pkg.sv
// Shared widths and writeback source encodings for the WB-stage register file.
package wb_regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_RSV = 2'b11
    } result_src_e;
endpackage

// File: rtl/wb_mux.sv
// Writeback source select; purely combinational so its output can also feed forwarding.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [1:0]   result_src,
    input  logic [W-1:0] read_data,
    input  logic [W-1:0] alu_result,
    input  logic [W-1:0] pc_add4,
    output logic [W-1:0] result
);
    always_comb begin
        result = alu_result;
        case (result_src)
            RES_MEM: result = read_data;
            RES_PC4: result = pc_add4;
            // The reserved code falls back to the ALU result.
            default: result = alu_result;
        endcase
    end
endmodule

// File: rtl/wb_regfile.sv
// Flop-based register file written from WB with write-through bypass,
// plus a retire counter and the PC of the most recent register write.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREG = wb_regfile_pkg::NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            RegWrite_WB,
    input  logic [1:0]      ResultSrc_WB,
    input  logic [XLEN-1:0] ReadData_WB,
    input  logic [XLEN-1:0] ALU_result_WB,
    input  logic [XLEN-1:0] PCadd4_WB,
    input  logic [XLEN-1:0] PC_WB,
    input  logic [AW-1:0]   rac_WB,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] Result_WB,
    output logic [XLEN-1:0] retire_cnt,
    output logic [XLEN-1:0] last_pc
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;

    wb_mux #(.W(XLEN)) u_wb_mux (
        .result_src (ResultSrc_WB),
        .read_data  (ReadData_WB),
        .alu_result (ALU_result_WB),
        .pc_add4    (PCadd4_WB),
        .result     (Result_WB)
    );

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (RegWrite_WB && (rac_WB == AW'(i)))
                regs_d[i] = Result_WB;
        end
        retire_cnt_d = RegWrite_WB ? retire_cnt_q + 1'b1 : retire_cnt_q;
        last_pc_d    = RegWrite_WB ? PC_WB : last_pc_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            retire_cnt_q <= '0;
            last_pc_q    <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= regs_d[i];
            retire_cnt_q <= retire_cnt_d;
            last_pc_q    <= last_pc_d;
        end
    end

    // Bypass is gated by RSTN so both ports read zero throughout reset.
    always_comb begin
        rd1 = regs_q[ra1];
        rd2 = regs_q[ra2];
        if (RSTN && RegWrite_WB && (rac_WB == ra1))
            rd1 = Result_WB;
        if (RSTN && RegWrite_WB && (rac_WB == ra2))
            rd2 = Result_WB;
    end

    assign retire_cnt = retire_cnt_q;
    assign last_pc    = last_pc_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expectations, a negedge monitor checks them.
module tb_wb_regfile;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic        RegWrite_WB;
    logic [1:0]  ResultSrc_WB;
    logic [31:0] ReadData_WB, ALU_result_WB, PCadd4_WB, PC_WB;
    logic [4:0]  rac_WB, ra1, ra2;
    logic [31:0] rd1, rd2, Result_WB, retire_cnt, last_pc;

    wb_regfile dut (
        .CLK(CLK), .RSTN(RSTN), .RegWrite_WB(RegWrite_WB), .ResultSrc_WB(ResultSrc_WB),
        .ReadData_WB(ReadData_WB), .ALU_result_WB(ALU_result_WB), .PCadd4_WB(PCadd4_WB),
        .PC_WB(PC_WB), .rac_WB(rac_WB), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .Result_WB(Result_WB), .retire_cnt(retire_cnt), .last_pc(last_pc)
    );

    always #5 CLK = ~CLK;

    typedef enum int { O_RD1, O_RD2, O_RES, O_CNT, O_LPC } obs_e;
    typedef struct {
        string       name;
        obs_e        obs;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_v(input string name, input obs_e obs, input logic [31:0] val);
        exp_t e;
        e.name = name; e.obs = obs; e.val = val;
        exp_q.push_back(e);
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.obs)
                O_RD1:   act = rd1;
                O_RD2:   act = rd2;
                O_RES:   act = Result_WB;
                O_CNT:   act = retire_cnt;
                default: act = last_pc;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %08h want %08h", e.name, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic [4:0] rac,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [31:0] pc,
                         input logic [4:0] a1, input logic [4:0] a2);
        RegWrite_WB = we; ResultSrc_WB = src; rac_WB = rac; ALU_result_WB = alu;
        ReadData_WB = mem; PCadd4_WB = pc4; PC_WB = pc; ra1 = a1; ra2 = a2;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, a1, a2);
    endtask

    initial begin
        RSTN = 1'b0;
        idle(5'd0, 5'd0);
        #1;
        expect_v("reset_rd1", O_RD1, 32'h0);
        expect_v("reset_cnt", O_CNT, 32'h0);
        expect_v("reset_lpc", O_LPC, 32'h0);
        step();
        RSTN = 1'b1;
        step();

        // ALU write to r5 with same-cycle bypass, then stored read.
        drive(1, 2'b00, 5'd5, 32'h12345678, 32'h0, 32'h0, 32'h40, 5'd5, 5'd0);
        expect_v("alu_bypass", O_RD1, 32'h12345678);
        expect_v("alu_result", O_RES, 32'h12345678);
        expect_v("cnt_before", O_CNT, 32'h0);
        step();
        idle(5'd5, 5'd0);
        expect_v("alu_stored", O_RD1, 32'h12345678);
        expect_v("cnt_1", O_CNT, 32'h1);
        expect_v("lpc_40", O_LPC, 32'h40);
        step();

        // Load into r3, then link into r31.
        drive(1, 2'b01, 5'd3, 32'h0, 32'hDEADBEEF, 32'h0, 32'hFC, 5'd0, 5'd0);
        expect_v("mem_result", O_RES, 32'hDEADBEEF);
        step();
        drive(1, 2'b10, 5'd31, 32'h0, 32'h0, 32'h104, 32'h100, 5'd3, 5'd31);
        expect_v("r3_stored", O_RD1, 32'hDEADBEEF);
        expect_v("r31_bypass", O_RD2, 32'h104);
        step();

        // Disabled write to r7 must not land.
        drive(0, 2'b00, 5'd7, 32'hFFFF, 32'h0, 32'h0, 32'h999, 5'd31, 5'd3);
        expect_v("r31_stored", O_RD1, 32'h104);
        expect_v("r3_again", O_RD2, 32'hDEADBEEF);
        expect_v("lpc_100", O_LPC, 32'h100);
        expect_v("cnt_3", O_CNT, 32'h3);
        expect_v("nowe_no_bypass", O_RD1, 32'h104);
        step();
        idle(5'd7, 5'd0);
        expect_v("r7_unwritten", O_RD1, 32'h0);
        expect_v("cnt_hold", O_CNT, 32'h3);
        expect_v("lpc_hold", O_LPC, 32'h100);
        step();

        // Reserved source selects the ALU result.
        drive(1, 2'b11, 5'd9, 32'hA5, 32'h11, 32'h22, 32'h200, 5'd0, 5'd0);
        expect_v("rsv_result", O_RES, 32'hA5);
        step();
        idle(5'd9, 5'd0);
        expect_v("r9_rsv", O_RD1, 32'hA5);
        expect_v("cnt_4", O_CNT, 32'h4);
        step();

        // Dual read of the register being written.
        drive(1, 2'b00, 5'd9, 32'h55, 32'h0, 32'h0, 32'h204, 5'd9, 5'd9);
        expect_v("dual_rd1", O_RD1, 32'h55);
        expect_v("dual_rd2", O_RD2, 32'h55);
        step();
        drive(1, 2'b00, 5'd0, 32'h1, 32'h0, 32'h0, 32'h208, 5'd9, 5'd9);
        expect_v("dual_st1", O_RD1, 32'h55);
        expect_v("dual_st2", O_RD2, 32'h55);
        step();
        idle(5'd0, 5'd0);
        expect_v("r0_rd1", O_RD1, 32'h1);
        expect_v("r0_rd2", O_RD2, 32'h1);
        expect_v("cnt_6", O_CNT, 32'h6);
        expect_v("lpc_208", O_LPC, 32'h208);
        step();

        // Flushed entry: no state change.
        drive(0, 2'b00, 5'd0, 32'hBAD, 32'h0, 32'h0, 32'h555, 5'd0, 5'd0);
        step();
        idle(5'd0, 5'd0);
        expect_v("flush_r0", O_RD1, 32'h1);
        expect_v("flush_cnt", O_CNT, 32'h6);
        expect_v("flush_lpc", O_LPC, 32'h208);
        step();

        // Write r4, then reset lands while the next write is pending.
        drive(1, 2'b00, 5'd4, 32'hCAFE, 32'h0, 32'h0, 32'h300, 5'd0, 5'd0);
        step();
        idle(5'd4, 5'd0);
        expect_v("r4_cafe", O_RD1, 32'hCAFE);
        expect_v("cnt_7", O_CNT, 32'h7);
        step();
        drive(1, 2'b00, 5'd4, 32'h1111, 32'h0, 32'h0, 32'h304, 5'd4, 5'd9);
        RSTN = 1'b0;
        #1;
        expect_v("rst_rd1", O_RD1, 32'h0);
        expect_v("rst_rd2", O_RD2, 32'h0);
        expect_v("rst_cnt", O_CNT, 32'h0);
        expect_v("rst_lpc", O_LPC, 32'h0);
        step();
        expect_v("rst_held_rd1", O_RD1, 32'h0);
        expect_v("rst_held_cnt", O_CNT, 32'h0);
        step();

        // Write presented with reset release is taken on the very next edge.
        RSTN = 1'b1;
        drive(1, 2'b00, 5'd2, 32'h77, 32'h0, 32'h0, 32'h400, 5'd0, 5'd0);
        step();
        idle(5'd2, 5'd4);
        expect_v("first_wr", O_RD1, 32'h77);
        expect_v("r4_lost", O_RD2, 32'h0);
        expect_v("first_cnt", O_CNT, 32'h1);
        expect_v("first_lpc", O_LPC, 32'h400);
        step();

        // Counter wrap from all-ones.
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        drive(1, 2'b00, 5'd6, 32'h66, 32'h0, 32'h0, 32'h500, 5'd0, 5'd0);
        expect_v("cnt_max", O_CNT, 32'hFFFFFFFF);
        step();
        idle(5'd6, 5'd0);
        expect_v("cnt_wrap", O_CNT, 32'h0);
        expect_v("r6_wr", O_RD1, 32'h66);
        step();
        step();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
